// File: rtl/tap_arb_pkg.sv
// Shared types and constants for the tap-coefficient BRAM arbiter.
package tap_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_CFG = 1'b0,
    OWN_ENG = 1'b1
  } owner_t;

  // Wide enough for data paths up to 128 bits; the top slices what it needs.
  localparam logic [15:0] WE_ALL = 16'hFFFF;

endpackage

// File: rtl/tap_bram_arbiter_starve_counter.sv
// Saturating count of consecutive cycles a cfg read was denied during a run.
module starve_counter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_hit
);

  localparam int CW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [CW-1:0] HIT_VAL = CW'(STARVE_LIMIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != HIT_VAL)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_hit = (r_cnt == HIT_VAL);

endmodule

// File: rtl/tap_bram_arbiter.sv
// Arbitrates the single-port tap BRAM between the AXI4-Lite cfg path and the
// FIR engine, sequencing ownership with ap_start/ap_done.
//
//   state | meaning
//   IDLE  | cfg owns the BRAM, reads and writes granted on request
//   RUN   | engine has priority; cfg reads only, with starvation relief
//   DRAIN | one cycle, no grants, lets the last read return
module tap_bram_arbiter
  import tap_arb_pkg::*;
#(
  parameter int pADDR_WIDTH  = 12,
  parameter int pDATA_WIDTH  = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     in_ap_start,
  input  logic                     in_ap_done,
  input  logic                     in_cfg_req,
  input  logic                     in_cfg_we,
  input  logic [pADDR_WIDTH-1:0]   in_cfg_addr,
  input  logic [pDATA_WIDTH-1:0]   in_cfg_wdata,
  output logic                     out_cfg_gnt,
  output logic                     out_cfg_rvalid,
  output logic [pDATA_WIDTH-1:0]   out_cfg_rdata,
  input  logic                     in_eng_req,
  input  logic [pADDR_WIDTH-1:0]   in_eng_addr,
  output logic                     out_eng_gnt,
  output logic                     out_eng_rvalid,
  output logic [pDATA_WIDTH-1:0]   out_eng_rdata,
  output logic                     out_EN,
  output logic [pDATA_WIDTH/8-1:0] out_WE,
  output logic [pADDR_WIDTH-1:0]   out_A,
  output logic [pDATA_WIDTH-1:0]   out_Di,
  input  logic [pDATA_WIDTH-1:0]   in_Do,
  output logic                     out_busy
);

  localparam int WEW = pDATA_WIDTH / 8;

  arb_state_t               r_state;
  owner_t                   r_rd_owner;
  logic                     r_rd_pending;
  logic [pADDR_WIDTH-1:0]   r_A;
  logic [pDATA_WIDTH-1:0]   r_Di;

  logic                     w_hit;
  logic                     w_cfg_rd;
  logic                     w_cfg_gnt;
  logic                     w_eng_gnt;
  logic                     w_cfg_wr_gnt;
  logic                     w_rd_gnt;
  logic                     w_any_gnt;
  logic                     w_starve_inc;
  logic [pADDR_WIDTH-1:0]   w_A_drv;

  assign w_cfg_rd = in_cfg_req & ~in_cfg_we;

  // Grants are suppressed while reset is held so every output reads zero.
  always_comb begin
    w_cfg_gnt = 1'b0;
    w_eng_gnt = 1'b0;
    if (aresetn) begin
      case (r_state)
        IDLE: w_cfg_gnt = in_cfg_req;
        RUN: begin
          w_eng_gnt = in_eng_req & ~(w_cfg_rd & w_hit);
          w_cfg_gnt = w_cfg_rd & (~in_eng_req | w_hit);
        end
        default: ;
      endcase
    end
  end

  assign w_cfg_wr_gnt = w_cfg_gnt & in_cfg_we;
  assign w_rd_gnt     = w_eng_gnt | (w_cfg_gnt & ~in_cfg_we);
  assign w_any_gnt    = w_eng_gnt | w_cfg_gnt;
  assign w_A_drv      = (w_eng_gnt ? in_eng_addr : in_cfg_addr) & ~pADDR_WIDTH'(3);
  assign w_starve_inc = (r_state == RUN) & w_cfg_rd & ~w_cfg_gnt;

  starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .aclk    (aclk),
    .aresetn (aresetn),
    .i_inc   (w_starve_inc),
    .i_clr   (~w_starve_inc),
    .o_hit   (w_hit)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= IDLE;
      r_rd_pending <= 1'b0;
      r_rd_owner   <= OWN_CFG;
      r_A          <= '0;
      r_Di         <= '0;
    end else begin
      r_rd_pending <= w_rd_gnt;
      if (w_rd_gnt)     r_rd_owner <= w_eng_gnt ? OWN_ENG : OWN_CFG;
      if (w_any_gnt)    r_A        <= w_A_drv;
      if (w_cfg_wr_gnt) r_Di       <= in_cfg_wdata;
      case (r_state)
        IDLE:    if (in_ap_start) r_state <= RUN;
        RUN:     if (in_ap_done)  r_state <= DRAIN;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_cfg_gnt    = w_cfg_gnt;
  assign out_eng_gnt    = w_eng_gnt;
  assign out_EN         = w_any_gnt;
  assign out_WE         = w_cfg_wr_gnt ? WE_ALL[WEW-1:0] : '0;
  assign out_A          = w_any_gnt ? w_A_drv : r_A;
  assign out_Di         = w_cfg_wr_gnt ? in_cfg_wdata : r_Di;
  assign out_cfg_rvalid = r_rd_pending & (r_rd_owner == OWN_CFG);
  assign out_eng_rvalid = r_rd_pending & (r_rd_owner == OWN_ENG);
  assign out_cfg_rdata  = out_cfg_rvalid ? in_Do : '0;
  assign out_eng_rdata  = out_eng_rvalid ? in_Do : '0;
  assign out_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_tap_bram_arbiter.sv
// Randomized and directed bench for tap_bram_arbiter with a cycle-level
// reference model and a behavioural BRAM.
module tb_tap_bram_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int LIMIT = 8;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic ap_start, ap_done, cfg_req, cfg_we, eng_req;
  logic [AW-1:0] cfg_addr, eng_addr;
  logic [DW-1:0] cfg_wdata;
  logic cfg_gnt, cfg_rvalid, eng_gnt, eng_rvalid, en, busy;
  logic [DW-1:0] cfg_rdata, eng_rdata, di;
  logic [DW-1:0] in_Do = '0;
  logic [3:0] we;
  logic [AW-1:0] a;

  int total = 0;
  int bad = 0;

  always #5 aclk = ~aclk;

  tap_bram_arbiter #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .aclk(aclk), .aresetn(aresetn), .in_ap_start(ap_start), .in_ap_done(ap_done),
    .in_cfg_req(cfg_req), .in_cfg_we(cfg_we), .in_cfg_addr(cfg_addr), .in_cfg_wdata(cfg_wdata),
    .out_cfg_gnt(cfg_gnt), .out_cfg_rvalid(cfg_rvalid), .out_cfg_rdata(cfg_rdata),
    .in_eng_req(eng_req), .in_eng_addr(eng_addr), .out_eng_gnt(eng_gnt),
    .out_eng_rvalid(eng_rvalid), .out_eng_rdata(eng_rdata), .out_EN(en), .out_WE(we),
    .out_A(a), .out_Di(di), .in_Do(in_Do), .out_busy(busy)
  );

  // Behavioural BRAM: unwritten words return a seeded pattern.
  logic [DW-1:0] seed;
  logic [DW-1:0] mem [0:1023];
  bit            wr_flag [0:1023];

  function automatic logic [DW-1:0] init_word(int idx);
    return (32'(idx) * 32'h9E37_79B1) ^ seed;
  endfunction

  always @(posedge aclk) begin
    if (en) begin
      if (we != 4'h0) begin
        mem[a[AW-1:2]] <= di;
        wr_flag[a[AW-1:2]] <= 1'b1;
      end
      in_Do <= wr_flag[a[AW-1:2]] ? mem[a[AW-1:2]] : init_word(int'(a[AW-1:2]));
    end
  end

  // Reference model state (phase 0=idle 1=run 2=drain) and expected outputs.
  logic [DW-1:0] ref_mem [0:1023];
  int m_phase, m_starve;
  bit m_pend, m_pend_eng;
  logic [DW-1:0] m_pend_data, m_last_di;
  logic [AW-1:0] m_last_a;
  bit e_cfg_gnt, e_eng_gnt, e_cfg_rv, e_eng_rv, e_en, e_busy;
  logic [3:0] e_we;
  logic [AW-1:0] e_a;
  logic [DW-1:0] e_di, e_cfg_rd, e_eng_rd;

  task automatic clear_inputs();
    ap_start = 0; ap_done = 0; cfg_req = 0; cfg_we = 0; eng_req = 0;
    cfg_addr = '0; eng_addr = '0; cfg_wdata = '0;
  endtask

  task automatic model_reset();
    m_phase = 0; m_starve = 0; m_pend = 0; m_pend_eng = 0;
    m_pend_data = '0; m_last_a = '0; m_last_di = '0;
  endtask

  task automatic predict();
    bit rd, frc;
    rd  = cfg_req && !cfg_we;
    frc = rd && (m_starve == LIMIT - 1);
    e_cfg_gnt = 0;
    e_eng_gnt = 0;
    if (aresetn) begin
      if (m_phase == 0) e_cfg_gnt = cfg_req;
      else if (m_phase == 1) begin
        e_eng_gnt = eng_req && !frc;
        e_cfg_gnt = rd && (!eng_req || frc);
      end
    end
    e_en     = e_cfg_gnt || e_eng_gnt;
    e_we     = (e_cfg_gnt && cfg_we) ? 4'hF : 4'h0;
    e_a      = !e_en ? m_last_a : ((e_eng_gnt ? eng_addr : cfg_addr) & 12'hFFC);
    e_di     = (e_cfg_gnt && cfg_we) ? cfg_wdata : m_last_di;
    e_cfg_rv = m_pend && !m_pend_eng;
    e_eng_rv = m_pend && m_pend_eng;
    e_cfg_rd = e_cfg_rv ? m_pend_data : '0;
    e_eng_rd = e_eng_rv ? m_pend_data : '0;
    e_busy   = (m_phase != 0);
  endtask

  task automatic cycle_start();
    @(negedge aclk);
    predict();
  endtask

  task automatic advance();
    if (e_cfg_gnt && cfg_we) ref_mem[cfg_addr[AW-1:2]] = cfg_wdata;
    m_pend_data = e_eng_gnt ? ref_mem[eng_addr[AW-1:2]] : ref_mem[cfg_addr[AW-1:2]];
    m_pend      = e_eng_gnt || (e_cfg_gnt && !cfg_we);
    m_pend_eng  = e_eng_gnt;
    m_last_a    = e_a;
    m_last_di   = e_di;
    m_starve    = (m_phase == 1 && cfg_req && !cfg_we && !e_cfg_gnt) ? m_starve + 1 : 0;
    case (m_phase)
      0: if (ap_start) m_phase = 1;
      1: if (ap_done) m_phase = 2;
      default: m_phase = 0;
    endcase
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    aresetn = 0;
    model_reset();
    repeat (2) @(posedge aclk);
    #1;
    cfg_req = 1; eng_req = 1; cfg_addr = 12'h0FF; cfg_wdata = 32'hDEAD_BEEF; cfg_we = 1;
    @(negedge aclk);
    total++; if ({cfg_gnt, eng_gnt, cfg_rvalid, eng_rvalid, en, busy} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 000000", {cfg_gnt, eng_gnt, cfg_rvalid, eng_rvalid, en, busy}); end
    total++; if ({we, a, di, cfg_rdata, eng_rdata} !== 112'h0) begin
      bad++; $display("FAIL reset_bus: we=%h a=%h di=%h crd=%h erd=%h want all 0", we, a, di, cfg_rdata, eng_rdata); end
    @(posedge aclk);
    #1;
    clear_inputs();
    aresetn = 1;
    cycle_start();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    advance();
  endtask

  task automatic test_idle_cfg();
    cfg_req = 1; cfg_we = 1; cfg_addr = 12'h008; cfg_wdata = 32'h0000_0011;
    cycle_start();
    total++; if (cfg_gnt !== 1'b1) begin bad++; $display("FAIL idle_wr_gnt: got %b want 1", cfg_gnt); end
    total++; if (en !== 1'b1) begin bad++; $display("FAIL idle_wr_en: got %b want 1", en); end
    total++; if (we !== 4'hF) begin bad++; $display("FAIL idle_wr_we: got %h want f", we); end
    total++; if (a !== 12'h008) begin bad++; $display("FAIL idle_wr_a: got %h want 008", a); end
    total++; if (di !== 32'h11) begin bad++; $display("FAIL idle_wr_di: got %h want 11", di); end
    advance();
    cfg_we = 0;
    cycle_start();
    total++; if (cfg_gnt !== 1'b1) begin bad++; $display("FAIL idle_rd_gnt: got %b want 1", cfg_gnt); end
    total++; if (cfg_rvalid !== 1'b0) begin bad++; $display("FAIL idle_rd_early: got %b want 0", cfg_rvalid); end
    advance();
    cfg_req = 0;
    cycle_start();
    total++; if (cfg_rvalid !== 1'b1) begin bad++; $display("FAIL idle_rd_rvalid: got %b want 1", cfg_rvalid); end
    total++; if (cfg_rdata !== 32'h11) begin bad++; $display("FAIL idle_rd_data: got %h want 11", cfg_rdata); end
    total++; if (en !== 1'b0 || a !== 12'h008) begin
      bad++; $display("FAIL idle_hold: en=%b a=%h want en=0 a=008", en, a); end
    advance();
  endtask

  task automatic test_run_eng();
    ap_start = 1;
    cycle_start();
    advance();
    ap_start = 0;
    for (int i = 0; i < 5; i++) begin
      eng_req = (i < 4);
      eng_addr = 12'(i * 4);
      cycle_start();
      if (i < 4) begin
        total++; if (eng_gnt !== 1'b1) begin bad++; $display("FAIL run_eng_gnt%0d: got %b want 1", i, eng_gnt); end
      end
      if (i > 0) begin
        total++; if (eng_rvalid !== 1'b1 || eng_rdata !== ref_mem[i-1]) begin
          bad++; $display("FAIL run_eng_rd%0d: rv=%b data=%h want rv=1 data=%h", i, eng_rvalid, eng_rdata, ref_mem[i-1]); end
      end
      total++; if (cfg_rvalid !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL run_eng_side%0d: cfg_rv=%b busy=%b want 0 1", i, cfg_rvalid, busy); end
      advance();
    end
    eng_req = 0;
  endtask

  task automatic test_cfg_write_stall();
    cfg_req = 1; cfg_we = 1; cfg_addr = 12'h010; cfg_wdata = 32'hA5A5_0F0F;
    for (int i = 0; i < 6; i++) begin
      ap_done = (i == 3);
      cycle_start();
      if (i < 5) begin
        total++; if (cfg_gnt !== 1'b0 || we !== 4'h0) begin
          bad++; $display("FAIL stall_wr%0d: gnt=%b we=%h want 0 0", i, cfg_gnt, we); end
      end
      if (i == 4) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL stall_drain_busy: got %b want 1", busy); end
      end
      if (i == 5) begin
        total++; if (cfg_gnt !== 1'b1 || we !== 4'hF || busy !== 1'b0) begin
          bad++; $display("FAIL stall_idle_wr: gnt=%b we=%h busy=%b want 1 f 0", cfg_gnt, we, busy); end
      end
      advance();
    end
    clear_inputs();
    cfg_req = 1; cfg_addr = 12'h010;
    cycle_start();
    advance();
    cfg_req = 0;
    cycle_start();
    total++; if (cfg_rdata !== 32'hA5A5_0F0F) begin
      bad++; $display("FAIL stall_readback: got %h want a5a50f0f", cfg_rdata); end
    advance();
  endtask

  task automatic test_starve();
    int n;
    bit got;
    ap_start = 1;
    cycle_start();
    advance();
    ap_start = 0;
    eng_req = 1; cfg_req = 1; cfg_we = 0; cfg_addr = 12'h024;
    for (int rep = 0; rep < 2; rep++) begin
      n = 0;
      got = 0;
      while (!got && n < 20) begin
        eng_addr = 12'($urandom);
        cycle_start();
        n++;
        if (cfg_gnt === 1'b1) begin
          got = 1;
          total++; if (eng_gnt !== 1'b0) begin bad++; $display("FAIL starve_eng_denied: got %b want 0", eng_gnt); end
        end
        total++; if (eng_gnt !== e_eng_gnt || eng_rvalid !== e_eng_rv || eng_rdata !== e_eng_rd) begin
          bad++; $display("FAIL starve_eng: gnt=%b rv=%b d=%h want %b %b %h", eng_gnt, eng_rvalid, eng_rdata, e_eng_gnt, e_eng_rv, e_eng_rd); end
        total++; if (cfg_rvalid !== e_cfg_rv || cfg_rdata !== e_cfg_rd) begin
          bad++; $display("FAIL starve_cfg_rd: rv=%b d=%h want %b %h", cfg_rvalid, cfg_rdata, e_cfg_rv, e_cfg_rd); end
        advance();
      end
      total++; if (!got || n != LIMIT) begin
        bad++; $display("FAIL starve_grant_cycle%0d: got cycle %0d (granted=%b) want %0d", rep, n, got, LIMIT); end
    end
    clear_inputs();
    cycle_start();
    total++; if (cfg_rvalid !== 1'b1 || cfg_rdata !== ref_mem[9]) begin
      bad++; $display("FAIL starve_rd_data: rv=%b d=%h want 1 %h", cfg_rvalid, cfg_rdata, ref_mem[9]); end
    advance();
    ap_done = 1;
    cycle_start();
    advance();
    ap_done = 0;
    cycle_start();
    advance();
  endtask

  task automatic test_done_read_drain();
    ap_start = 1;
    cycle_start();
    advance();
    ap_start = 0;
    eng_req = 1; eng_addr = 12'h044; ap_done = 1;
    cycle_start();
    total++; if (eng_gnt !== 1'b1) begin bad++; $display("FAIL done_eng_gnt: got %b want 1", eng_gnt); end
    advance();
    clear_inputs();
    cfg_req = 1; cfg_addr = 12'h008;
    cycle_start();
    total++; if (eng_rvalid !== 1'b1 || eng_rdata !== ref_mem[17] || cfg_rvalid !== 1'b0) begin
      bad++; $display("FAIL drain_eng_rd: rv=%b d=%h crv=%b want 1 %h 0", eng_rvalid, eng_rdata, cfg_rvalid, ref_mem[17]); end
    total++; if (cfg_gnt !== 1'b0 || en !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL drain_nogrant: gnt=%b en=%b busy=%b want 0 0 1", cfg_gnt, en, busy); end
    advance();
    cycle_start();
    total++; if (busy !== 1'b0 || cfg_gnt !== 1'b1) begin
      bad++; $display("FAIL drain_to_idle: busy=%b gnt=%b want 0 1", busy, cfg_gnt); end
    advance();
    cfg_req = 0;
    cycle_start();
    total++; if (cfg_rvalid !== 1'b1 || cfg_rdata !== 32'h11) begin
      bad++; $display("FAIL idle_after_drain_rd: rv=%b d=%h want 1 11", cfg_rvalid, cfg_rdata); end
    advance();
    ap_start = 1; ap_done = 1;
    cycle_start();
    advance();
    cfg_req = 1; cfg_we = 0; cfg_addr = 12'h013;
    cycle_start();
    total++; if (cfg_gnt !== 1'b1 || a !== 12'h010 || busy !== 1'b1) begin
      bad++; $display("FAIL done_cfg_gnt: gnt=%b a=%h busy=%b want 1 010 1", cfg_gnt, a, busy); end
    advance();
    clear_inputs();
    cycle_start();
    total++; if (cfg_rvalid !== 1'b1 || cfg_rdata !== 32'hA5A5_0F0F || eng_rvalid !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL drain_cfg_rd: rv=%b d=%h erv=%b busy=%b want 1 a5a50f0f 0 1", cfg_rvalid, cfg_rdata, eng_rvalid, busy); end
    advance();
    cycle_start();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL drain_busy_end: got %b want 0", busy); end
    advance();
  endtask

  task automatic test_reset_midflight();
    ap_start = 1;
    cycle_start();
    advance();
    ap_start = 0;
    eng_req = 1; eng_addr = 12'h0F0;
    cycle_start();
    total++; if (eng_gnt !== 1'b1) begin bad++; $display("FAIL midrst_gnt: got %b want 1", eng_gnt); end
    advance();
    aresetn = 0;
    model_reset();
    cycle_start();
    total++; if (eng_rvalid !== 1'b0) begin bad++; $display("FAIL midrst_rvalid: got %b want 0", eng_rvalid); end
    total++; if ({cfg_gnt, eng_gnt, cfg_rvalid, en, busy, we, a, di, cfg_rdata, eng_rdata} !== 117'h0) begin
      bad++; $display("FAIL midrst_outputs: en=%b busy=%b a=%h erd=%h want all 0", en, busy, a, eng_rdata); end
    @(posedge aclk);
    #1;
    aresetn = 1;
    cycle_start();
    total++; if (busy !== 1'b0 || eng_gnt !== 1'b0 || eng_rvalid !== 1'b0) begin
      bad++; $display("FAIL midrst_release: busy=%b gnt=%b rv=%b want 0 0 0", busy, eng_gnt, eng_rvalid); end
    advance();
    clear_inputs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      ap_start = ($urandom_range(0, 15) == 0);
      ap_done  = ($urandom_range(0, 19) == 0);
      if (!cfg_req || e_cfg_gnt) begin
        cfg_req   = $urandom_range(0, 1);
        cfg_we    = ($urandom_range(0, 3) == 0);
        cfg_addr  = 12'($urandom);
        cfg_wdata = $urandom;
      end
      eng_req  = ($urandom_range(0, 3) != 0);
      eng_addr = 12'($urandom);
      cycle_start();
      total++; if (cfg_gnt !== e_cfg_gnt || eng_gnt !== e_eng_gnt) begin
        bad++; $display("FAIL rnd_gnt c%0d: cfg=%b eng=%b want %b %b", c, cfg_gnt, eng_gnt, e_cfg_gnt, e_eng_gnt); end
      total++; if (en !== e_en || we !== e_we) begin
        bad++; $display("FAIL rnd_en_we c%0d: en=%b we=%h want %b %h", c, en, we, e_en, e_we); end
      total++; if (a !== e_a || di !== e_di) begin
        bad++; $display("FAIL rnd_a_di c%0d: a=%h di=%h want %h %h", c, a, di, e_a, e_di); end
      total++; if (cfg_rvalid !== e_cfg_rv || cfg_rdata !== e_cfg_rd) begin
        bad++; $display("FAIL rnd_cfg_rd c%0d: rv=%b d=%h want %b %h", c, cfg_rvalid, cfg_rdata, e_cfg_rv, e_cfg_rd); end
      total++; if (eng_rvalid !== e_eng_rv || eng_rdata !== e_eng_rd) begin
        bad++; $display("FAIL rnd_eng_rd c%0d: rv=%b d=%h want %b %h", c, eng_rvalid, eng_rdata, e_eng_rv, e_eng_rd); end
      total++; if (busy !== e_busy) begin
        bad++; $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, e_busy); end
      advance();
    end
    clear_inputs();
  endtask

  initial begin
    seed = $urandom;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    clear_inputs();
    model_reset();
    e_cfg_gnt = 0;
    test_reset();
    test_idle_cfg();
    test_run_eng();
    test_cfg_write_stall();
    test_starve();
    test_done_read_drain();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
